// File: rtl/riscv_pkg.sv
// Shared RV32 decode definitions: opcode constants, immediate formats and the
// per-opcode operand/destination usage table used by the operand fetch stage.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef struct packed {
    logic      legal;
    logic      uses_rs1;
    logic      uses_rs2;
    logic      writes_rd;
    imm_type_e imm_type;
  } decode_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            illegal;
  } out_t;

  // Any opcode outside the table (including instr[1:0] != 2'b11) decodes as
  // illegal with no operands, no destination and a zero immediate.
  function automatic decode_t decode_opcode(input logic [6:0] opc);
    decode_t d;
    d = '{legal: 1'b0, uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b0,
          imm_type: IMM_NONE};
    case (opc)
      OPC_LUI:    d = '{1'b1, 1'b0, 1'b0, 1'b1, IMM_U};
      OPC_AUIPC:  d = '{1'b1, 1'b0, 1'b0, 1'b1, IMM_U};
      OPC_JAL:    d = '{1'b1, 1'b0, 1'b0, 1'b1, IMM_J};
      OPC_JALR:   d = '{1'b1, 1'b1, 1'b0, 1'b1, IMM_I};
      OPC_BRANCH: d = '{1'b1, 1'b1, 1'b1, 1'b0, IMM_B};
      OPC_LOAD:   d = '{1'b1, 1'b1, 1'b0, 1'b1, IMM_I};
      OPC_STORE:  d = '{1'b1, 1'b1, 1'b1, 1'b0, IMM_S};
      OPC_OP_IMM: d = '{1'b1, 1'b1, 1'b0, 1'b1, IMM_I};
      OPC_OP:     d = '{1'b1, 1'b1, 1'b1, 1'b1, IMM_NONE};
      default:    ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32 immediate generator: sign-extended I/S/B/U/J formats,
// zero for formats without an immediate.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);

  // Opcode bits carry no immediate information.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^instr[6:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    imm = '0;
    case (imm_type)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: reads the register file, bypasses the current
// write-back, stalls on load-use hazards and presents a registered bundle.
module operand_fetch
  import riscv_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rf_addr_a,
  output logic [4:0]      rf_addr_b,
  input  logic [XLEN-1:0] rf_data_a,
  input  logic [XLEN-1:0] rf_data_b,
  input  logic            wb_valid,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_load_valid,
  input  logic [4:0]      ex_load_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            out_illegal
);

  decode_t         dec;
  logic [4:0]      addr_a;
  logic [4:0]      addr_b;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] opnd_a;
  logic [XLEN-1:0] opnd_b;
  logic            hazard;
  logic            transfer;

  out_t out_d, out_q;
  logic out_valid_d, out_valid_q;

  assign dec = decode_opcode(in_instr[6:0]);

  imm_gen u_imm_gen (
    .instr    (in_instr),
    .imm_type (dec.imm_type),
    .imm      (imm)
  );

  // Unused source fields read x0 so they can neither bypass nor stall.
  always_comb begin
    addr_a = dec.uses_rs1 ? in_instr[19:15] : 5'd0;
    addr_b = dec.uses_rs2 ? in_instr[24:20] : 5'd0;
  end

  assign rf_addr_a = addr_a;
  assign rf_addr_b = addr_b;

  always_comb begin
    opnd_a = rf_data_a;
    if (addr_a == 5'd0) begin
      opnd_a = '0;
    end else if (BYPASS_EN && wb_valid && (wb_addr == addr_a)) begin
      opnd_a = wb_data;
    end

    opnd_b = rf_data_b;
    if (addr_b == 5'd0) begin
      opnd_b = '0;
    end else if (BYPASS_EN && wb_valid && (wb_addr == addr_b)) begin
      opnd_b = wb_data;
    end
  end

  assign hazard = ex_load_valid && (ex_load_rd != 5'd0) &&
                  ((ex_load_rd == addr_a) || (ex_load_rd == addr_b));

  assign in_ready = !reset && !flush && !hazard && (!out_valid_q || out_ready);
  assign transfer = in_valid && in_ready;

  // Flush wins over everything; the payload is only ever replaced by a transfer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (transfer) begin
      out_valid_d    = 1'b1;
      out_d.pc       = in_pc;
      out_d.rs1_data = opnd_a;
      out_d.rs2_data = opnd_b;
      out_d.rs1      = addr_a;
      out_d.rs2      = addr_b;
      out_d.rd       = dec.writes_rd ? in_instr[11:7] : 5'd0;
      out_d.imm      = imm;
      out_d.opcode   = in_instr[6:0];
      out_d.funct3   = in_instr[14:12];
      out_d.funct7b5 = in_instr[30];
      out_d.illegal  = !dec.legal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_q.pc;
  assign out_rs1_data = out_q.rs1_data;
  assign out_rs2_data = out_q.rs2_data;
  assign out_rs1      = out_q.rs1;
  assign out_rs2      = out_q.rs2;
  assign out_rd       = out_q.rd;
  assign out_imm      = out_q.imm;
  assign out_opcode   = out_q.opcode;
  assign out_funct3   = out_q.funct3;
  assign out_funct7b5 = out_q.funct7b5;
  assign out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, hand-written handshake
// sequences and a randomized run against a reference model (bypass on and off).
module tb_operand_fetch;

  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67,
                         BRANCH = 7'h63, LOAD = 7'h03, STORE = 7'h23,
                         OPIMM = 7'h13, OP = 7'h33;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, flush, out_ready, wb_valid, ex_load_valid;
  logic [31:0] in_instr, in_pc, rf_data_a, rf_data_b, wb_data;
  logic [4:0]  wb_addr, ex_load_rd;

  // Outputs of the bypassing instance (_b) and the non-bypassing one (_n).
  logic        in_ready_b, out_valid_b, f7_b, ill_b;
  logic [4:0]  ra_b, rb_b, rs1_b, rs2_b, rd_b;
  logic [31:0] pc_b, rs1d_b, rs2d_b, imm_b;
  logic [6:0]  opc_b;
  logic [2:0]  f3_b;
  logic        in_ready_n, out_valid_n, f7_n, ill_n;
  logic [4:0]  ra_n, rb_n, rs1_n, rs2_n, rd_n;
  logic [31:0] pc_n, rs1d_n, rs2d_n, imm_n;
  logic [6:0]  opc_n;
  logic [2:0]  f3_n;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  operand_fetch #(.BYPASS_EN(1'b1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .in_pc(in_pc), .rf_addr_a(ra_b), .rf_addr_b(rb_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .ex_load_valid(ex_load_valid),
    .ex_load_rd(ex_load_rd), .flush(flush), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_pc(pc_b), .out_rs1_data(rs1d_b),
    .out_rs2_data(rs2d_b), .out_rs1(rs1_b), .out_rs2(rs2_b), .out_rd(rd_b),
    .out_imm(imm_b), .out_opcode(opc_b), .out_funct3(f3_b),
    .out_funct7b5(f7_b), .out_illegal(ill_b)
  );

  operand_fetch #(.BYPASS_EN(1'b0)) dut_n (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_instr(in_instr), .in_pc(in_pc), .rf_addr_a(ra_n), .rf_addr_b(rb_n),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .ex_load_valid(ex_load_valid),
    .ex_load_rd(ex_load_rd), .flush(flush), .out_valid(out_valid_n),
    .out_ready(out_ready), .out_pc(pc_n), .out_rs1_data(rs1d_n),
    .out_rs2_data(rs2d_n), .out_rs1(rs1_n), .out_rs2(rs2_n), .out_rd(rd_n),
    .out_imm(imm_n), .out_opcode(opc_n), .out_funct3(f3_n),
    .out_funct7b5(f7_n), .out_illegal(ill_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc, rs1d, rs1d_nb, rs2d, rs2d_nb, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7, ill, hazard;
  } pred_t;

  function automatic logic [31:0] opnd(input logic [4:0] a, input logic [31:0] rf, input bit byp);
    if (a == 0) return 32'd0;
    if (byp && wb_valid && wb_addr == a) return wb_data;
    return rf;
  endfunction

  function automatic pred_t predict();
    pred_t p;
    logic [6:0] o;
    bit legal, r1, r2, wr;
    o     = in_instr[6:0];
    legal = o inside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP};
    r1    = o inside {OP, OPIMM, LOAD, STORE, BRANCH, JALR};
    r2    = o inside {OP, STORE, BRANCH};
    wr    = o inside {LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP};
    if (o inside {OPIMM, LOAD, JALR})
      p.imm = 32'($signed(in_instr[31:20]));
    else if (o == STORE)
      p.imm = 32'($signed({in_instr[31:25], in_instr[11:7]}));
    else if (o == BRANCH)
      p.imm = 32'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
    else if (o inside {LUI, AUIPC})
      p.imm = {in_instr[31:12], 12'd0};
    else if (o == JAL)
      p.imm = 32'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
    else
      p.imm = 32'd0;
    p.rs1     = r1 ? in_instr[19:15] : 5'd0;
    p.rs2     = r2 ? in_instr[24:20] : 5'd0;
    p.rd      = wr ? in_instr[11:7] : 5'd0;
    p.rs1d    = opnd(p.rs1, rf_data_a, 1'b1);
    p.rs1d_nb = opnd(p.rs1, rf_data_a, 1'b0);
    p.rs2d    = opnd(p.rs2, rf_data_b, 1'b1);
    p.rs2d_nb = opnd(p.rs2, rf_data_b, 1'b0);
    p.opc     = o;
    p.f3      = in_instr[14:12];
    p.f7      = in_instr[30];
    p.ill     = !legal;
    p.pc      = in_pc;
    p.hazard  = ex_load_valid && ex_load_rd != 0 &&
                (ex_load_rd == p.rs1 || ex_load_rd == p.rs2);
    return p;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] instr, rfa, rfb;
    logic        wbv;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        exv;
    logic [4:0]  exrd;
    logic        ready;
    logic [31:0] rs1d, rs1d_nb, rs2d, rs2d_nb, imm;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  vec_t vecs[15];

  task automatic idle_inputs();
    in_valid = 0; flush = 0; out_ready = 1; wb_valid = 0; wb_addr = 0;
    wb_data = 0; ex_load_valid = 0; ex_load_rd = 0; rf_data_a = 0;
    rf_data_b = 0; in_instr = 32'h00000013; in_pc = 0;
  endtask

  pred_t m_out;
  logic  m_valid;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{32'hFFF08293, 7, 32'h99, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0, 32'hFFFFFFFF, 5, 0};
    vecs[1]  = '{32'h002081B3, 32'h55, 32'h11, 1, 2, 32'hAA, 0, 0, 1, 32'h55, 32'h55, 32'hAA, 32'h11, 0, 3, 0};
    vecs[2]  = '{32'h002081B3, 32'h55, 32'h11, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{32'h002081B3, 32'h55, 32'h11, 0, 0, 0, 1, 0, 1, 32'h55, 32'h55, 32'h11, 32'h11, 0, 3, 0};
    vecs[4]  = '{32'h123450B7, 5, 6, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 32'h12345000, 1, 0};
    vecs[5]  = '{32'hFE000EE3, 5, 6, 1, 0, 9, 0, 0, 1, 0, 0, 0, 0, 32'hFFFFFFFC, 0, 0};
    vecs[6]  = '{32'h00000000, 5, 6, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    vecs[7]  = '{32'h0020A423, 32'h10, 32'h20, 1, 0, 32'hDEAD, 0, 0, 1, 32'h10, 32'h10, 32'h20, 32'h20, 8, 0, 0};
    vecs[8]  = '{32'h0020A423, 32'h10, 32'h20, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{32'hFF9FF0EF, 5, 6, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'hFFFFFFF8, 1, 0};
    vecs[10] = '{32'hFFFFF117, 5, 6, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'hFFFFF000, 2, 0};
    vecs[11] = '{32'hFFC0A203, 9, 6, 1, 1, 32'h1234, 0, 0, 1, 32'h1234, 9, 0, 0, 32'hFFFFFFFC, 4, 0};
    vecs[12] = '{32'h000001B3, 5, 6, 1, 0, 32'h77, 0, 0, 1, 0, 0, 0, 0, 0, 3, 0};
    vecs[13] = '{32'h00000012, 5, 6, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    vecs[14] = '{32'hFFF08293, 7, 0, 0, 0, 0, 1, 31, 1, 7, 7, 0, 0, 32'hFFFFFFFF, 5, 0};

    // Reset state, checked before any clock edge.
    idle_inputs();
    in_valid = 1;
    reset = 1;
    #3;
    check("reset out_valid", {31'd0, out_valid_b}, 0);
    check("reset in_ready", {31'd0, in_ready_b}, 0);
    check("reset out_pc", pc_b, 0);
    check("reset out_imm", imm_b, 0);
    @(posedge clk); #1;
    reset = 0;
    in_valid = 0;

    // Vector table: back-to-back issue with out_ready held high.
    for (int i = 0; i < 15; i++) begin
      in_valid = 1; out_ready = 1; flush = 0;
      in_instr = vecs[i].instr; in_pc = 32'h1000 + 32'(i * 4);
      rf_data_a = vecs[i].rfa; rf_data_b = vecs[i].rfb;
      wb_valid = vecs[i].wbv; wb_addr = vecs[i].wba; wb_data = vecs[i].wbd;
      ex_load_valid = vecs[i].exv; ex_load_rd = vecs[i].exrd;
      #2;
      check($sformatf("vec%0d in_ready", i), {31'd0, in_ready_b}, {31'd0, vecs[i].ready});
      @(posedge clk); #1;
      check($sformatf("vec%0d out_valid", i), {31'd0, out_valid_b}, {31'd0, vecs[i].ready});
      if (vecs[i].ready) begin
        check($sformatf("vec%0d out_pc", i), pc_b, 32'h1000 + 32'(i * 4));
        check($sformatf("vec%0d rs1_data byp", i), rs1d_b, vecs[i].rs1d);
        check($sformatf("vec%0d rs1_data nobyp", i), rs1d_n, vecs[i].rs1d_nb);
        check($sformatf("vec%0d rs2_data byp", i), rs2d_b, vecs[i].rs2d);
        check($sformatf("vec%0d rs2_data nobyp", i), rs2d_n, vecs[i].rs2d_nb);
        check($sformatf("vec%0d imm", i), imm_b, vecs[i].imm);
        check($sformatf("vec%0d rd", i), {27'd0, rd_b}, {27'd0, vecs[i].rd});
        check($sformatf("vec%0d illegal", i), {31'd0, ill_b}, {31'd0, vecs[i].ill});
      end
    end
    idle_inputs();

    // Backpressure: three stalled cycles, then accept when out_ready returns.
    in_valid = 1; in_instr = 32'hFFF08293; in_pc = 32'h2000; rf_data_a = 7;
    @(posedge clk); #1;
    check("bp first valid", {31'd0, out_valid_b}, 1);
    in_instr = 32'h002081B3; in_pc = 32'h2004; out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #2;
      check($sformatf("bp%0d in_ready", c), {31'd0, in_ready_b}, 0);
      @(posedge clk); #1;
      check($sformatf("bp%0d out_valid", c), {31'd0, out_valid_b}, 1);
      check($sformatf("bp%0d out_pc", c), pc_b, 32'h2000);
      check($sformatf("bp%0d out_imm", c), imm_b, 32'hFFFFFFFF);
      check($sformatf("bp%0d rs1_data", c), rs1d_b, 7);
    end
    out_ready = 1;
    #2;
    check("bp release in_ready", {31'd0, in_ready_b}, 1);
    @(posedge clk); #1;
    check("bp release out_pc", pc_b, 32'h2004);
    check("bp release out_rd", {27'd0, rd_b}, 3);

    // Flush while holding: drop the valid, accept nothing.
    out_ready = 0; in_valid = 1; in_instr = 32'hFFF08293; in_pc = 32'h3000; flush = 1;
    #2;
    check("flush in_ready", {31'd0, in_ready_b}, 0);
    @(posedge clk); #1;
    check("flush out_valid", {31'd0, out_valid_b}, 0);
    check("flush no transfer", pc_b, 32'h2004);
    flush = 0;

    // Reset in the middle of a hold acts without a clock edge.
    out_ready = 1;
    @(posedge clk); #1;
    check("pre-reset transfer", pc_b, 32'h3000);
    out_ready = 0;
    @(posedge clk); #1;
    check("pre-reset hold", {31'd0, out_valid_b}, 1);
    #2;
    reset = 1;
    #1;
    check("async reset out_valid", {31'd0, out_valid_b}, 0);
    check("async reset out_pc", pc_b, 0);
    check("async reset in_ready", {31'd0, in_ready_b}, 0);
    @(posedge clk); #1;
    check("reset held discard", {31'd0, out_valid_b}, 0);
    reset = 0;
    idle_inputs();

    // Randomized run against the reference model.
    m_valid = 0;
    for (int n = 0; n < 400; n++) begin
      pred_t p;
      bit exp_ready;
      logic [6:0] opcs[9];
      opcs = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP};
      in_instr = $urandom;
      if ($urandom_range(0, 9) != 0) in_instr[6:0] = opcs[$urandom_range(0, 8)];
      in_instr[19:15] = 5'($urandom_range(0, 3));
      in_instr[24:20] = 5'($urandom_range(0, 3));
      in_pc = $urandom;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      rf_data_a = $urandom; rf_data_b = $urandom;
      wb_valid = $urandom_range(0, 1); wb_addr = 5'($urandom_range(0, 3)); wb_data = $urandom;
      ex_load_valid = ($urandom_range(0, 2) == 0); ex_load_rd = 5'($urandom_range(0, 3));
      #2;
      p = predict();
      exp_ready = !flush && !p.hazard && (!m_valid || out_ready);
      check("rnd in_ready byp", {31'd0, in_ready_b}, {31'd0, exp_ready});
      check("rnd in_ready nobyp", {31'd0, in_ready_n}, {31'd0, exp_ready});
      check("rnd rf_addr_a", {27'd0, ra_b}, {27'd0, p.rs1});
      check("rnd rf_addr_b", {27'd0, rb_b}, {27'd0, p.rs2});
      if (flush) m_valid = 0;
      else if (in_valid && exp_ready) begin m_valid = 1; m_out = p; end
      else if (out_ready) m_valid = 0;
      @(posedge clk); #1;
      check("rnd out_valid byp", {31'd0, out_valid_b}, {31'd0, m_valid});
      check("rnd out_valid nobyp", {31'd0, out_valid_n}, {31'd0, m_valid});
      if (m_valid) begin
        check("rnd out_pc", pc_b, m_out.pc);
        check("rnd rs1_data byp", rs1d_b, m_out.rs1d);
        check("rnd rs1_data nobyp", rs1d_n, m_out.rs1d_nb);
        check("rnd rs2_data byp", rs2d_b, m_out.rs2d);
        check("rnd rs2_data nobyp", rs2d_n, m_out.rs2d_nb);
        check("rnd imm", imm_b, m_out.imm);
        check("rnd rs1", {27'd0, rs1_b}, {27'd0, m_out.rs1});
        check("rnd rs2", {27'd0, rs2_b}, {27'd0, m_out.rs2});
        check("rnd rd", {27'd0, rd_b}, {27'd0, m_out.rd});
        check("rnd opcode", {25'd0, opc_b}, {25'd0, m_out.opc});
        check("rnd funct3", {29'd0, f3_b}, {29'd0, m_out.f3});
        check("rnd funct7b5", {31'd0, f7_b}, {31'd0, m_out.f7});
        check("rnd illegal", {31'd0, ill_b}, {31'd0, m_out.ill});
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
